// File: rtl/image_stream_tx.sv
// Raster-order pixel source: reads one IMG_WIDTH x IMG_HEIGHT frame from sync RAM.
// Optional `FLUSH_PAD_EN appends FLUSH_LEN zero pixels to drain downstream pipelines.
module image_stream_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FLUSH_LEN  = IMG_WIDTH*4+5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic                          stall,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid_out,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_out,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_out,
  output logic                          last_out,
  output logic                          busy,
  output logic                          done
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FLUSH
  } state_t;

  state_t                state_q;
  logic [RW-1:0]         r_q;
  logic [CW-1:0]         c_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  vld_q;
  logic                  last_q;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         col_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  busy_q;
  logic                  done_q;

  logic rd_en;
  logic at_end;

  assign rd_en  = (state_q == READ) && !stall;
  assign at_end = (r_q == RW'(IMG_HEIGHT-1)) &&
                  (c_q == CW'(IMG_WIDTH-1));

`ifdef FLUSH_PAD_EN
  localparam int FW = $clog2(FLUSH_LEN+1);

  logic [FW-1:0] fcnt_q;
  logic          pad;

  // Pad cycles are emitted directly from FLUSH; a stalled cycle emits nothing.
  assign pad = (state_q == FLUSH) && !stall;

  assign data_valid_out = vld_q || pad;
  assign data_out       = vld_q ? mem_data :
                          pad   ? '0       : hold_q;
`else
  assign data_valid_out = vld_q;
  assign data_out       = vld_q ? mem_data : hold_q;
`endif

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign row_out   = row_q;
  assign col_out   = col_q;
  assign last_out  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FLUSH_PAD_EN
      fcnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      vld_q  <= rd_en;
      last_q <= rd_en && at_end;
      if (rd_en) begin
        row_q <= r_q;
        col_q <= c_q;
      end
      if (vld_q) begin
        hold_q <= mem_data;
      end
`ifdef FLUSH_PAD_EN
      if (pad) begin
        hold_q <= '0;
      end
`endif
      unique case (state_q)
        IDLE: begin
          // done_q gate: a start coinciding with the done pulse is dropped.
          if (start && !done_q) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            r_q     <= '0;
            c_q     <= '0;
            addr_q  <= ADDR_WIDTH'(BASE_ADDR);
          end
        end
        READ: begin
          if (!stall) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (c_q == CW'(IMG_WIDTH-1)) begin
              c_q <= '0;
              r_q <= r_q + RW'(1);
            end else begin
              c_q <= c_q + CW'(1);
            end
            if (at_end) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
`ifdef FLUSH_PAD_EN
          state_q <= FLUSH;
          fcnt_q  <= '0;
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`endif
        end
        FLUSH: begin
`ifdef FLUSH_PAD_EN
          if (!stall) begin
            if (fcnt_q == FW'(FLUSH_LEN-1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              fcnt_q <= fcnt_q + FW'(1);
            end
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_tx.sv
// Directed bench for image_stream_tx: reset, full frames, stall, ignored
// starts and mid-frame reset, with an optional FLUSH_PAD_EN tail.
module tb_image_stream_tx;

  localparam int DW   = 16;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int AW   = 10;
  localparam int RW   = $clog2(H);
  localparam int CW   = $clog2(W);
  localparam int NPIX = W*H;
`ifdef FLUSH_PAD_EN
  localparam int PADS = W*4+5;
`else
  localparam int PADS = 0;
`endif

  logic          CLK;
  logic          RST;
  logic          start;
  logic          stall;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] data_out;
  logic          data_valid_out;
  logic [RW-1:0] row_out;
  logic [CW-1:0] col_out;
  logic          last_out;
  logic          busy;
  logic          done;

  int ncmp = 0;
  int nerr = 0;

  logic [DW-1:0] mem [1024];

  image_stream_tx #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_WIDTH(AW),
    .BASE_ADDR (0)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .stall         (stall),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
    .row_out       (row_out),
    .col_out       (col_out),
    .last_out      (last_out),
    .busy          (busy),
    .done          (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(data_valid_out), 0);
    chk({tag, ".data"},  32'(data_out), 0);
    chk({tag, ".row"},   32'(row_out), 0);
    chk({tag, ".col"},   32'(col_out), 0);
    chk({tag, ".last"},  32'(last_out), 0);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, ".addr"},  32'(mem_addr), 0);
  endtask

  // Start a frame in cycle 0 and follow it cycle by cycle.
  // sp/sn: stall sn cycles starting when pixel sp would be read.
  // rs: cycle of an extra start pulse while busy (0 = none).
  task automatic frame(input string tag, input int sp, input int sn,
                       input int rs);
    int pix, pads, bad, bbad, nd, dc, expd, expc;
    expd = NPIX + 2 + PADS + sn;
    pix = 0; pads = 0; bad = 0; bbad = 0; nd = 0; dc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= expd + 5; t++) begin
      stall = (sn > 0) && (t >= sp + 1) && (t <= sp + sn);
      start = (t == rs) || (t == expd);
      #1;
      if (stall && mem_rd_en) bad++;
      if (data_valid_out) begin
        if (pix < NPIX) begin
          expc = pix + 2 + ((sn > 0 && pix >= sp) ? sn : 0);
          if (data_out !== DW'(pix) || row_out !== RW'(pix / W) ||
              col_out !== CW'(pix % W) ||
              last_out !== (pix == NPIX - 1) || t != expc) bad++;
          pix++;
        end else begin
          expc = NPIX + 2 + sn + pads;
          if (data_out !== '0 || last_out !== 1'b0 ||
              row_out !== RW'(H - 1) || col_out !== CW'(W - 1) ||
              t != expc) bad++;
          pads++;
        end
      end else if (last_out) begin
        bad++;
      end
      if (busy !== (t < expd)) bbad++;
      if (done) begin
        nd++;
        dc = t;
      end
      tick();
    end
    stall = 1'b0;
    start = 1'b0;
    chk({tag, ".pixels"},  32'(pix), 32'(NPIX));
    chk({tag, ".pads"},    32'(pads), 32'(PADS));
    chk({tag, ".pix_err"}, 32'(bad), 0);
    chk({tag, ".busy_err"}, 32'(bbad), 0);
    chk({tag, ".n_done"},  32'(nd), 1);
    chk({tag, ".done_cyc"}, 32'(dc), 32'(expd));
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    RST   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) tick();
    chk_zero("reset");

    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rd_en || data_valid_out || busy || done ||
          data_out !== '0 || mem_addr !== '0) bad++;
    end
    chk("idle.err", 32'(bad), 0);

    frame("plain", 0, 0, 0);
    frame("stall", 30, 5, 0);
    frame("restart", 0, 0, 100);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (399) tick();
    chk("mid.valid", 32'(data_valid_out), 1);
    chk("mid.data",  32'(data_out), 398);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_zero("rst_mid");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rd_en || data_valid_out || busy || done) bad++;
    end
    chk("rst_mid.quiet", 32'(bad), 0);

    frame("after_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/image_stream_tx.md
Name: image_stream_tx

Overview:
- Source end of the pixel-stream interface consumed by the 5x5 window line-buffer stage: fetches one IMG_WIDTH x IMG_HEIGHT feature map from a synchronous-read memory and emits it raster-order as data/valid pairs.
- Supports start/busy/done control, downstream stall and per-pixel row/col tags.
- Sits between the feature-map RAM and the first line-buffer/convolution stage.

Parameters:
- DATA_WIDTH, 16, pixel width.
- IMG_WIDTH, 28, pixels per row.
- IMG_HEIGHT, 28, rows per frame.
- ADDR_WIDTH, 10, memory address width; must satisfy 2^ADDR_WIDTH >= BASE_ADDR + IMG_WIDTH*IMG_HEIGHT.
- BASE_ADDR, 0, address of pixel (0,0).
- FLUSH_LEN, IMG_WIDTH*4+5, number of zero pixels emitted after the frame; used only with FLUSH_PAD_EN.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request to stream one frame; ignored while busy=1.
- stall  in  1  downstream hold; while 1, no new memory read is issued.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  read address, valid when mem_rd_en=1.
- mem_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- data_out  out  DATA_WIDTH  pixel to line buffer.
- data_valid_out  out  1  data_out valid this cycle.
- row_out  out  $clog2(IMG_HEIGHT)  row of data_out.
- col_out  out  $clog2(IMG_WIDTH)  column of data_out.
- last_out  out  1  qualifies the final frame pixel (row H-1, col W-1).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  1-cycle pulse at end of frame.

Behaviour:
- Reset: state IDLE. All outputs 0, including mem_addr, data_out, row/col tags, last_out, busy and done. Reset mid-frame aborts immediately with no done pulse; no residual valid after RST deasserts.
- FSM IDLE -> READ -> DRAIN -> (FLUSH) -> IDLE.
  - IDLE: start=1 -> READ, busy=1, read counters cleared.
  - READ: each cycle with stall=0, assert mem_rd_en with mem_addr = BASE_ADDR + r*IMG_WIDTH + c, then advance c (wrap to 0 at IMG_WIDTH-1, incrementing r). With stall=1: mem_rd_en=0 and counters hold. After issuing read (H-1, W-1) -> DRAIN.
  - DRAIN: one cycle for the last read to return -> FLUSH (macro on) or IDLE with done=1, busy=0.
- Output pipeline:
  - data_valid_out is mem_rd_en delayed 1 cycle; data_out = mem_data in that cycle.
  - row_out, col_out and last_out are registered alongside data_out.
  - When data_valid_out=0, data_out holds its last value.
- Stall: one read already in flight is still emitted the cycle after stall rises; downstream must accept it. Stall never drops or duplicates a pixel.
- Latency, no stall: start sampled in cycle 0; reads in cycles 1..W*H; valid pixels in cycles 2..W*H+1; done in cycle W*H+2 (786 at defaults). Throughput 1 pixel/cycle.
- Simultaneous events:
  - start and stall together: start is accepted, first read waits for stall=0.
  - start in the same cycle as done: start is ignored.
- Address arithmetic is unsigned and truncated to ADDR_WIDTH.

Optional Feature:
- Macro FLUSH_PAD_EN.
- Defined: after DRAIN, state FLUSH emits FLUSH_LEN cycles of data_out=0, data_valid_out=1, last_out=0, with row/col tags frozen at the last pixel. These cycles obey stall: a stalled cycle emits no valid and does not count. done pulses the cycle after the final pad, at cycle W*H+2+FLUSH_LEN with no stall (903 at defaults). This drains the downstream valid-delay pipelines.
- Undefined: FLUSH state absent; done timing as in Behaviour.

Test Plan:
- Reset/idle: RST=1 for 3 cycles, then idle 10 cycles -> all outputs 0, mem_rd_en never asserted.
- Full frame, no stall, memory preloaded with mem[i]=i: start in cycle 0 -> 784 valid pixels in cycles 2..785 with data 0..783 in order; row/col tags match raster index; last_out only at pixel 783; done exactly in cycle 786; busy high cycles 1..785.
- Stall mid-row: assert stall for 5 cycles when pixel 30 is being read -> exactly one more pixel is emitted after stall rises, then a 5-cycle gap, then the sequence resumes at the next pixel with no gaps or duplicates; done is delayed by 5 cycles.
- Start while busy: pulse start again at cycle 100 -> ignored; exactly 784 pixels and one done pulse.
- Reset mid-frame: RST at cycle 400 for 1 cycle -> outputs 0 the next cycle, no done pulse. A new start then streams a fresh frame beginning at address BASE_ADDR.
- FLUSH_PAD_EN defined: full frame -> 784 data pixels followed by 117 zero-valued valid pixels; done in cycle 903.
